// File: rtl/gpio_debounce.sv
// Two-channel button debouncer for remote-board GPIO levels.
// Each channel has a 2-flop synchronizer and a four-state debounce FSM
// that needs DEBOUNCE_CYCLES consecutive stable samples before it
// accepts a level change. Any bounce during a wait restarts the count.
// Outputs are the debounced levels, one-cycle press/release pulses and
// a registered AND of both levels.
module gpio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic gpio_l,
    input  logic gpio_r,
    output logic btn_l,
    output logic btn_r,
    output logic press_l,
    output logic press_r,
    output logic release_l,
    output logic release_r,
    output logic btn_both
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    // Terminal count: reached after DEBOUNCE_CYCLES stable samples in a WAIT state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] gpio_in;
    logic [1:0] btn;
    logic [1:0] press;
    logic [1:0] rel;

    assign gpio_in = {gpio_r, gpio_l};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic   sync1_q, sync1_d;
        logic   sync2_q, sync2_d;
        state_e state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic   btn_q, btn_d;
        logic   press_q, press_d;
        logic   rel_q, rel_d;

        // Synchronizer shift, debounce next-state/counter and output pulse decode.
        always_comb begin
            // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
            sync1_d = gpio_in[g];
            sync2_d = sync1_q;
            state_d = state_q;
            cnt_d   = cnt_q;

            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync2_q) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Debounced level follows the state being entered, so the pulses
            // line up with the first cycle the new level is visible.
            btn_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            press_d = btn_d && !btn_q;
            rel_d   = !btn_d && btn_q;
        end

        // Channel state register with synchronous reset; reset also clears the
        // synchronizer so a held input is debounced as a fresh press.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
                btn_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                btn_q   <= btn_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign btn[g]   = btn_q;
        assign press[g] = press_q;
        assign rel[g]   = rel_q;
    end

    logic btn_both_q, btn_both_d;

    // Both-buttons level lags the individual levels by one register.
    always_comb begin
        btn_both_d = btn[0] & btn[1];
    end

    // Both-buttons register.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_both_q <= 1'b0;
        end else begin
            btn_both_q <= btn_both_d;
        end
    end

    assign btn_l     = btn[0];
    assign btn_r     = btn[1];
    assign press_l   = press[0];
    assign press_r   = press[1];
    assign release_l = rel[0];
    assign release_r = rel[1];
    assign btn_both  = btn_both_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce (DEBOUNCE_CYCLES = 4).
// Stimulus pushes expected output events {cycle, press_l, press_r,
// release_l, release_r, btn_both}; the monitor pops one whenever the DUT
// shows a pulse or a btn_both change and compares cycle and values.
module tb_gpio_debounce;

    logic clk = 1'b0;
    logic rst;
    logic gpio_l, gpio_r;
    logic btn_l, btn_r, press_l, press_r, release_l, release_r, btn_both;

    gpio_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_l    (gpio_l),
        .gpio_r    (gpio_r),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .press_l   (press_l),
        .press_r   (press_r),
        .release_l (release_l),
        .release_r (release_r),
        .btn_both  (btn_both)
    );

    always #5 clk = ~clk;

    // Cycle number = rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event value bits: {press_l, press_r, release_l, release_r, btn_both}
    typedef struct {
        int         cyc;
        logic [4:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;
    logic both_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input applied now is sampled at the next edge; an event off edges later.
    task automatic expect_ev(input int off, input logic [4:0] v);
        ev_t e;
        e.cyc = cyc + off;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare each DUT event against the scoreboard head.
    always @(negedge clk) begin
        logic [4:0] act;
        ev_t        e;
        if (mon_en) begin
            act = {press_l, press_r, release_l, release_r, btn_both};
            if (press_l || press_r || release_l || release_r || (btn_both !== both_prev)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got %b expected none (cycle %0d)", act, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_outputs", {27'd0, act}, {27'd0, e.val});
                    check("press_with_release", {31'd0, (press_l & release_l) | (press_r & release_r)}, 32'd0);
                end
            end
            both_prev = btn_both;
        end
    end

    initial begin
        rst    = 1'b1;
        gpio_l = 1'b0;
        gpio_r = 1'b0;
        step(3);

        // Reset state
        check("rst_btn_l",     {31'd0, btn_l},     32'd0);
        check("rst_btn_r",     {31'd0, btn_r},     32'd0);
        check("rst_press_l",   {31'd0, press_l},   32'd0);
        check("rst_press_r",   {31'd0, press_r},   32'd0);
        check("rst_release_l", {31'd0, release_l}, 32'd0);
        check("rst_release_r", {31'd0, release_r}, 32'd0);
        check("rst_btn_both",  {31'd0, btn_both},  32'd0);
        step(1);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Clean press on left, then release
        gpio_l = 1'b1;
        expect_ev(7, 5'b10000);
        step(10);
        check("clean_btn_l", {31'd0, btn_l}, 32'd1);
        check("clean_btn_r", {31'd0, btn_r}, 32'd0);
        gpio_l = 1'b0;
        expect_ev(7, 5'b00100);
        step(10);
        check("clean_rel_btn_l", {31'd0, btn_l}, 32'd0);

        // Bounce rejection: two-cycle highs never reach the terminal count
        gpio_l = 1'b1; step(2);
        gpio_l = 1'b0; step(2);
        gpio_l = 1'b1; step(2);
        gpio_l = 1'b0; step(12);
        check("bounce_btn_l", {31'd0, btn_l}, 32'd0);

        // Bounce during press: 3 high, 1 low, then held high
        gpio_l = 1'b1; step(3);
        gpio_l = 1'b0; step(1);
        gpio_l = 1'b1;
        expect_ev(7, 5'b10000);
        step(10);
        check("bpress_btn_l", {31'd0, btn_l}, 32'd1);
        gpio_l = 1'b0;
        expect_ev(7, 5'b00100);
        step(10);

        // Simultaneous press, then simultaneous release
        gpio_l = 1'b1;
        gpio_r = 1'b1;
        expect_ev(7, 5'b11000);
        expect_ev(8, 5'b00001);
        step(10);
        check("sim_btn_both", {31'd0, btn_both}, 32'd1);
        gpio_l = 1'b0;
        gpio_r = 1'b0;
        expect_ev(7, 5'b00111);
        expect_ev(8, 5'b00000);
        step(10);
        check("sim_rel_btn_both", {31'd0, btn_both}, 32'd0);

        // Staggered presses: channels independent
        gpio_r = 1'b1;
        expect_ev(7, 5'b01000);
        step(2);
        gpio_l = 1'b1;
        expect_ev(7, 5'b10000);
        expect_ev(8, 5'b00001);
        step(10);
        check("stag_btn_l", {31'd0, btn_l}, 32'd1);
        check("stag_btn_r", {31'd0, btn_r}, 32'd1);

        // Reset mid-PRESSED with inputs held: no release, fresh press after
        rst = 1'b1;
        expect_ev(1, 5'b00000);
        step(1);
        check("midrst_btn_l", {31'd0, btn_l}, 32'd0);
        check("midrst_btn_r", {31'd0, btn_r}, 32'd0);
        rst = 1'b0;
        expect_ev(7, 5'b11000);
        expect_ev(8, 5'b00001);
        step(10);
        check("postrst_btn_l", {31'd0, btn_l}, 32'd1);

        gpio_l = 1'b0;
        gpio_r = 1'b0;
        expect_ev(7, 5'b00111);
        expect_ev(8, 5'b00000);
        step(12);

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none expected %b at cycle %0d", e.val, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEBOUNCE_CYCLES)+1, meaning the debounce counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port gpio_l, input, 1 bit: the remote-board left-button level, registered but asynchronous to the local button logic and possibly bouncing.
REQ-006 SHALL have port gpio_r, input, 1 bit: the remote-board right-button level, with the same properties as gpio_l.
REQ-007 SHALL have port btn_l, output, 1 bit: the debounced left level.
REQ-008 SHALL have port btn_r, output, 1 bit: the debounced right level.
REQ-009 SHALL have port press_l and press_r, outputs, 1 bit each: one-cycle pulses that fire when the debounced level rises.
REQ-010 SHALL have port release_l and release_r, outputs, 1 bit each: one-cycle pulses that fire when the debounced level falls.
REQ-011 SHALL have port btn_both, output, 1 bit: registered btn_l AND btn_r.

Function
REQ-012 SHALL pass each input through a 2-flop synchronizer; s_x denotes the second-flop output.
REQ-013 SHALL run one independent FSM per channel, with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a CNT_W-bit counter.
REQ-014 In IDLE, the FSM SHALL go to PRESS_WAIT and clear the counter when s_x=1; otherwise it SHALL stay in IDLE.
REQ-015 In PRESS_WAIT, the FSM SHALL return to IDLE when s_x=0 and clear the counter.
REQ-016 In PRESS_WAIT with s_x=1 and counter=DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED; otherwise with s_x=1 it SHALL increment the counter.
REQ-017 In PRESSED, the FSM SHALL go to RELEASE_WAIT and clear the counter when s_x=0.
REQ-018 In RELEASE_WAIT, the FSM SHALL return to PRESSED when s_x=1.
REQ-019 In RELEASE_WAIT with s_x=0 and counter=DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE; otherwise with s_x=0 it SHALL increment the counter.
REQ-020 btn_x SHALL be registered and equal 1 exactly when the FSM state is PRESSED or RELEASE_WAIT.
REQ-021 press_x SHALL be high for exactly one cycle, on the same cycle that btn_x first reads 1.
REQ-022 release_x SHALL be high for exactly one cycle, on the same cycle that btn_x first reads 0.
REQ-023 Latency: when the input is sampled high at edge k and held, btn_x SHALL read 1 after edge k+2+DEBOUNCE_CYCLES, and release SHALL behave symmetrically.
REQ-024 An input pulse stable for fewer than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on btn_x, press_x or release_x.
REQ-025 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-026 Any abort from a WAIT state SHALL clear the counter; there SHALL be no partial-credit accumulation across bounces.
REQ-027 The channels SHALL be fully independent: simultaneous edges on gpio_l and gpio_r SHALL give simultaneous pulses with identical latency.
REQ-028 btn_both SHALL equal btn_l & btn_r with exactly one cycle of register delay.
REQ-029 press_x and release_x SHALL never be high in the same cycle.

Reset
REQ-030 While rst=1 at a clock edge, the synchronizer flops, all counters and all outputs SHALL be set to 0, and both FSMs SHALL be set to IDLE.
REQ-031 Reset asserted mid-operation (any state, any count value) SHALL take effect at the next edge and SHALL emit no release pulse.
REQ-032 When gpio_x is held 1 through reset deassertion, the block SHALL debounce it as a fresh press: press_x SHALL fire 2+DEBOUNCE_CYCLES cycles after the first edge with rst=0.

Verification
REQ-033 The bench SHALL cover a clean press with DEBOUNCE_CYCLES=4: gpio_l rises before edge 10 and is held -> btn_l=1 and press_l=1 after edge 16; press_l=0 after edge 17; btn_r, press_r and release_r stay 0.
REQ-034 The bench SHALL cover bounce rejection: gpio_l toggles 1,0,1,0 every 2 cycles, then stays 0 -> btn_l and press_l stay 0 throughout.
REQ-035 The bench SHALL cover a bounce during press: gpio_l high for 3 cycles, low for 1, then high and held -> exactly one press_l, timed 6 cycles after the final rising sample.
REQ-036 The bench SHALL cover simultaneous release: btn_l=btn_r=1, then both inputs fall on the same edge -> release_l and release_r pulse on the same cycle; btn_both falls one cycle after btn_l and btn_r fall.
REQ-037 The bench SHALL cover reset mid-PRESSED: btn_l=1, then rst is pulsed for 1 cycle -> btn_l=0 with no release_l pulse; with gpio_l still held 1, press_l fires 6 cycles after rst deasserts.
